// File: rtl/lane_seg_pkg.sv
// ---------------------------------------------------------------------------
// lane_seg_pkg
// Shared types, constants and helpers for the lane_seg requantisation stages.
//   state_e      : window FSM states (ACCUM -> ROUND -> EMIT)
//   ACC_*/OUT_*  : default widths and saturation bounds
//   sat_signed() : clamp a wide signed value into a signed range of 'width' bits
// ---------------------------------------------------------------------------
package lane_seg_pkg;

    localparam int PROD_WIDTH_DEF  = 21;
    localparam int ACC_WIDTH_DEF   = 32;
    localparam int BIAS_WIDTH_DEF  = 16;
    localparam int SHIFT_WIDTH_DEF = 5;
    localparam int OUT_WIDTH_DEF   = 8;
    localparam int MAX_TAPS_DEF    = 27;

    localparam logic signed [31:0] ACC_MAX = 32'sh7FFF_FFFF;
    localparam logic signed [31:0] ACC_MIN = 32'sh8000_0000;
    localparam logic signed [7:0]  OUT_MAX = 8'sh7F;
    localparam logic signed [7:0]  OUT_MIN = 8'sh80;

    typedef enum logic [1:0] {
        ACCUM = 2'd0,
        ROUND = 2'd1,
        EMIT  = 2'd2
    } state_e;

    // Clamp to [-(2^(width-1)), 2^(width-1)-1]. Callers detect clipping by
    // comparing the result with the input.
    function automatic logic signed [63:0] sat_signed(input logic signed [63:0] value,
                                                      input int width);
        logic signed [63:0] max_v;
        logic signed [63:0] min_v;
        max_v = (64'sd1 <<< (width - 1)) - 64'sd1;
        min_v = -(64'sd1 <<< (width - 1));
        if (value > max_v) begin
            return max_v;
        end else if (value < min_v) begin
            return min_v;
        end
        return value;
    endfunction

endpackage

// File: rtl/lane_seg_round_sat.sv
// ---------------------------------------------------------------------------
// lane_seg_round_sat
// Combinational requantiser: round-half-up arithmetic right shift, optional
// ReLU, then saturation to a signed OUT_WIDTH result.
//   value_i : signed input (IN_WIDTH)
//   shift_i : right shift amount
//   data_o  : saturated result (OUT_WIDTH)
//   clip_o  : 1 when the result had to be saturated
// ---------------------------------------------------------------------------
module lane_seg_round_sat
    import lane_seg_pkg::*;
#(
    parameter int IN_WIDTH    = 32,
    parameter int SHIFT_WIDTH = 5,
    parameter int OUT_WIDTH   = 8,
    parameter int RELU        = 1
) (
    input  logic signed [IN_WIDTH-1:0]    value_i,
    input  logic        [SHIFT_WIDTH-1:0] shift_i,
    output logic signed [OUT_WIDTH-1:0]   data_o,
    output logic                          clip_o
);

    // One extra bit so adding the rounding constant can never wrap.
    localparam int EXT_W = IN_WIDTH + 1;

    logic signed [EXT_W-1:0] ext_v;
    logic signed [EXT_W-1:0] half_v;
    logic signed [EXT_W-1:0] shifted_v;
    logic signed [EXT_W-1:0] relu_v;
    logic signed [63:0]      wide_v;

    always_comb begin
        ext_v  = EXT_W'(value_i);
        half_v = '0;
        if (shift_i != '0) begin
            half_v = {{(EXT_W-1){1'b0}}, 1'b1} << (shift_i - SHIFT_WIDTH'(1));
        end
        shifted_v = (ext_v + half_v) >>> shift_i;
        relu_v    = ((RELU != 0) && (shifted_v < 0)) ? '0 : shifted_v;
        wide_v    = 64'(relu_v);
        data_o    = OUT_WIDTH'(sat_signed(wide_v, OUT_WIDTH));
        clip_o    = (sat_signed(wide_v, OUT_WIDTH) != wide_v);
    end

endmodule

// File: rtl/lane_seg_requant_acc.sv
// ---------------------------------------------------------------------------
// lane_seg_requant_acc
// Accumulates one kernel window of signed products, adds bias, requantises
// (round, shift, optional ReLU, saturate) and emits one int8 result per window.
//   ap_clk / ap_rst              : clock, synchronous active-high reset
//   in_data/in_last/in_valid     : product stream, in_ready back-pressures
//   cfg_bias / cfg_shift         : sampled on the accepted closing beat
//   out_data/out_ovf/out_err     : result, saturation flag, forced-close flag
//   out_valid / out_ready        : result handshake
// ---------------------------------------------------------------------------
module lane_seg_requant_acc
    import lane_seg_pkg::*;
#(
    parameter int PROD_WIDTH  = PROD_WIDTH_DEF,
    parameter int ACC_WIDTH   = ACC_WIDTH_DEF,
    parameter int BIAS_WIDTH  = BIAS_WIDTH_DEF,
    parameter int SHIFT_WIDTH = SHIFT_WIDTH_DEF,
    parameter int OUT_WIDTH   = OUT_WIDTH_DEF,
    parameter int MAX_TAPS    = MAX_TAPS_DEF,
    parameter int RELU        = 1
) (
    input  logic                          ap_clk,
    input  logic                          ap_rst,
    input  logic signed [PROD_WIDTH-1:0]  in_data,
    input  logic                          in_last,
    input  logic                          in_valid,
    output logic                          in_ready,
    input  logic signed [BIAS_WIDTH-1:0]  cfg_bias,
    input  logic        [SHIFT_WIDTH-1:0] cfg_shift,
    output logic signed [OUT_WIDTH-1:0]   out_data,
    output logic                          out_ovf,
    output logic                          out_err,
    output logic                          out_valid,
    input  logic                          out_ready
);

    localparam int CNT_W = $clog2(MAX_TAPS);

    state_e                       state_q;
    logic signed [ACC_WIDTH-1:0]  acc_q;
    logic signed [ACC_WIDTH-1:0]  sum_q;
    logic [CNT_W-1:0]             tap_cnt_q;
    logic                         ovf_q;
    logic                         err_q;
    logic [SHIFT_WIDTH-1:0]       shift_q;
    logic signed [OUT_WIDTH-1:0]  out_data_q;
    logic                         out_ovf_q;
    logic                         out_err_q;
    logic                         out_valid_q;

    // Datapath next values
    logic signed [63:0]           step_ext;
    logic signed [63:0]           close_ext;
    logic signed [ACC_WIDTH-1:0]  acc_d;
    logic signed [ACC_WIDTH-1:0]  sum_d;
    logic                         step_clip;
    logic                         close_clip;
    logic                         last_tap;
    logic                         close_win;
    logic signed [OUT_WIDTH-1:0]  rs_data;
    logic                         rs_clip;

    always_comb begin
        step_ext   = 64'(acc_q) + 64'(in_data);
        close_ext  = step_ext + 64'(cfg_bias);
        acc_d      = ACC_WIDTH'(sat_signed(step_ext, ACC_WIDTH));
        sum_d      = ACC_WIDTH'(sat_signed(close_ext, ACC_WIDTH));
        step_clip  = (sat_signed(step_ext, ACC_WIDTH) != step_ext);
        close_clip = (sat_signed(close_ext, ACC_WIDTH) != close_ext);
        last_tap   = (tap_cnt_q == CNT_W'(MAX_TAPS - 1));
        close_win  = in_last || last_tap;
    end

    lane_seg_round_sat #(
        .IN_WIDTH    (ACC_WIDTH),
        .SHIFT_WIDTH (SHIFT_WIDTH),
        .OUT_WIDTH   (OUT_WIDTH),
        .RELU        (RELU)
    ) u_round_sat (
        .value_i (sum_q),
        .shift_i (shift_q),
        .data_o  (rs_data),
        .clip_o  (rs_clip)
    );

    always_ff @(posedge ap_clk) begin
        if (ap_rst) begin
            state_q     <= ACCUM;
            acc_q       <= '0;
            sum_q       <= '0;
            tap_cnt_q   <= '0;
            ovf_q       <= 1'b0;
            err_q       <= 1'b0;
            shift_q     <= '0;
            out_data_q  <= '0;
            out_ovf_q   <= 1'b0;
            out_err_q   <= 1'b0;
            out_valid_q <= 1'b0;
        end else begin
            unique case (state_q)
                ACCUM: begin
                    if (in_valid) begin
                        tap_cnt_q <= tap_cnt_q + CNT_W'(1);
                        if (close_win) begin
                            sum_q   <= sum_d;
                            ovf_q   <= ovf_q | close_clip;
                            // err only when the window was forced shut
                            err_q   <= last_tap && !in_last;
                            shift_q <= cfg_shift;
                            state_q <= ROUND;
                        end else begin
                            acc_q <= acc_d;
                            ovf_q <= ovf_q | step_clip;
                        end
                    end
                end
                ROUND: begin
                    out_data_q  <= rs_data;
                    out_ovf_q   <= ovf_q | rs_clip;
                    out_err_q   <= err_q;
                    out_valid_q <= 1'b1;
                    state_q     <= EMIT;
                end
                EMIT: begin
                    if (out_ready) begin
                        out_valid_q <= 1'b0;
                        acc_q       <= '0;
                        tap_cnt_q   <= '0;
                        ovf_q       <= 1'b0;
                        err_q       <= 1'b0;
                        state_q     <= ACCUM;
                    end
                end
                default: state_q <= ACCUM;
            endcase
        end
    end

    assign in_ready  = (state_q == ACCUM);
    assign out_data  = out_data_q;
    assign out_ovf   = out_ovf_q;
    assign out_err   = out_err_q;
    assign out_valid = out_valid_q;

endmodule
